// File: rtl/control_estacionamiento.sv
// rtl/control_estacionamiento.sv - parking-lot occupancy controller with debounced multi-lane sensors
module control_estacionamiento #(
  parameter int CAPACIDAD = 7,
  parameter int N_ENT     = 2,
  parameter int N_SAL     = 2,
  parameter int FILTRO    = 3,
  parameter int ANCHO     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_ENT-1:0] entrada,
  input  logic [N_SAL-1:0] salida,
  output logic [ANCHO-1:0] ocupados,
  output logic [ANCHO-1:0] libres,
  output logic             lleno,
  output logic             vacio,
  output logic             rechazo_ent,
  output logic             error_sal
);

  localparam int NS   = N_ENT + N_SAL;
  localparam int NMAX = (N_ENT > N_SAL) ? N_ENT : N_SAL;
  localparam int AW0  = $clog2(CAPACIDAD + NMAX + 1);
  localparam int AW   = (AW0 > ANCHO) ? AW0 : ANCHO;
  localparam int CW   = $clog2(FILTRO + 1);
  localparam logic [AW-1:0] CAP   = AW'(CAPACIDAD);
  localparam logic [CW-1:0] LIMIT = CW'(FILTRO - 1);

  logic [NS-1:0]    sens;
  logic [NS-1:0]    sync1_q, sync2_q;
  logic [NS-1:0]    filt_q, filt_d;
  logic [NS-1:0]    fprev_q;
  logic [CW-1:0]    cnt_q [NS];
  logic [CW-1:0]    cnt_d [NS];
  logic [NS-1:0]    ev;

  logic [AW-1:0]    ne, ns, occ, ns_ok, tmp, room, ne_ok, nxt;
  logic [ANCHO-1:0] ocupados_q, ocupados_d, libres_q, libres_d;
  logic             lleno_q, lleno_d, vacio_q, vacio_d;
  logic             rechazo_q, rechazo_d, error_q, error_d;

  assign sens = {salida, entrada};
  assign ev   = filt_q & ~fprev_q;

  // The filtered level flips on the FILTRO-th consecutive differing sample.
  always_comb begin
    filt_d = filt_q;
    for (int i = 0; i < NS; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != filt_q[i]) begin
        if (cnt_q[i] == LIMIT) filt_d[i] = sync2_q[i];
        else                   cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  always_comb begin
    ne = '0;
    ns = '0;
    for (int i = 0; i < N_ENT; i++) ne = ne + AW'(ev[i]);
    for (int i = 0; i < N_SAL; i++) ns = ns + AW'(ev[N_ENT + i]);
    occ   = AW'(ocupados_q);
    ns_ok = (ns < occ) ? ns : occ;
    tmp   = occ - ns_ok;
    room  = CAP - tmp;
    ne_ok = (ne < room) ? ne : room;
    nxt   = tmp + ne_ok;

    ocupados_d = ANCHO'(nxt);
    libres_d   = ANCHO'(CAP - nxt);
    lleno_d    = (nxt == CAP);
    vacio_d    = (nxt == '0);
    rechazo_d  = (ne_ok < ne);
    error_d    = (ns_ok < ns);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      filt_q     <= '0;
      fprev_q    <= '0;
      for (int i = 0; i < NS; i++) cnt_q[i] <= '0;
      ocupados_q <= '0;
      libres_q   <= ANCHO'(CAPACIDAD);
      lleno_q    <= 1'b0;
      vacio_q    <= 1'b1;
      rechazo_q  <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      sync1_q    <= sens;
      sync2_q    <= sync1_q;
      filt_q     <= filt_d;
      fprev_q    <= filt_q;
      for (int i = 0; i < NS; i++) cnt_q[i] <= cnt_d[i];
      ocupados_q <= ocupados_d;
      libres_q   <= libres_d;
      lleno_q    <= lleno_d;
      vacio_q    <= vacio_d;
      rechazo_q  <= rechazo_d;
      error_q    <= error_d;
    end
  end

  assign ocupados    = ocupados_q;
  assign libres      = libres_q;
  assign lleno       = lleno_q;
  assign vacio       = vacio_q;
  assign rechazo_ent = rechazo_q;
  assign error_sal   = error_q;

endmodule
